col_layer_ctrl: RTL and testbench
=================================

COL_LAYER_CTRL -- requirements
Module: col_layer_ctrl

Interface
REQ-001 The block SHALL have parameter COL_CNT_WID, default 7: width of the column counter.
REQ-002 The block SHALL have parameter COL_NUM, default 96: columns per iteration (2..2^COL_CNT_WID).
REQ-003 The block SHALL have parameter ITER_WID, default 5: width of the iteration counter.
REQ-004 The block SHALL have parameter FLUSH_CYC, default 3: CN/VN pipeline drain cycles after the last column.
REQ-005 The block SHALL have port i_clk, input, 1, clock.
REQ-006 The block SHALL have port i_rst_n, input, 1, synchronous active-low reset.
REQ-007 The block SHALL have port i_start, input, 1, start decode of one codeword.
REQ-008 The block SHALL have port i_stall, input, 1, freeze column advance (memory or upstream not ready).
REQ-009 The block SHALL have port i_max_iter, input, ITER_WID, maximum iterations, latched at start.
REQ-010 The block SHALL have port i_syn_ok, input, 1, syndrome all-zero flag, valid in the o_iter_end cycle.
REQ-011 The block SHALL have port o_busy, output, 1, high from start acceptance through the o_done cycle.
REQ-012 The block SHALL have port o_col_vld, output, 1, current column is processed this cycle.
REQ-013 The block SHALL have port o_col_cnt, output, COL_CNT_WID, current column index, fanned out to every cn_r i_col_cnt.
REQ-014 The block SHALL have port o_is_first_iter, output, 1, high throughout iteration 0, fanned out to cn_r i_is_first_iter.
REQ-015 The block SHALL have port o_iter_cnt, output, ITER_WID, current iteration index.
REQ-016 The block SHALL have port o_iter_end, output, 1, pulse coincident with the last column (COL_NUM-1) of each iteration.
REQ-017 The block SHALL have port o_done, output, 1, one-cycle completion pulse.
REQ-018 The block SHALL have port o_early_stop, output, 1, decode ended by syndrome; held until the next accepted start.

Function
REQ-019 The block SHALL implement FSM states IDLE, RUN, FLUSH and DONE, with all outputs registered.
REQ-020 In IDLE, i_start SHALL trigger: RUN, col_cnt=0, iter_cnt=0, first_iter=1, o_early_stop=0, and the latched max_iter = (i_max_iter==0 ? 1 : i_max_iter).
REQ-021 The block SHALL ignore i_start in every state other than IDLE.
REQ-022 In RUN with i_stall=0, the block SHALL assert o_col_vld and increment col_cnt each cycle.
REQ-023 In RUN with i_stall=1, the block SHALL hold o_col_vld=0 and freeze all counters; o_iter_end SHALL NOT assert during a stall.
REQ-024 At col_cnt==COL_NUM-1 with o_col_vld=1, the block SHALL assert o_iter_end, and on the next advance set col_cnt=0, iter_cnt+1 and first_iter=0.
REQ-025 When o_iter_end asserts and iter_cnt==max_iter-1, the block SHALL go to FLUSH.
REQ-026 In FLUSH, the block SHALL hold o_col_vld=0 for exactly FLUSH_CYC cycles, ignore i_stall, then go to DONE.
REQ-027 In DONE, the block SHALL pulse o_done for one cycle and return to IDLE; o_busy SHALL drop the cycle after o_done.
REQ-028 In IDLE, o_col_cnt, o_iter_cnt, o_col_vld, o_iter_end and o_is_first_iter SHALL be 0.
REQ-029 The start-to-first-o_col_vld latency SHALL be 1 cycle.

Reset
REQ-030 When i_rst_n=0 at a clock edge, the block SHALL enter IDLE and clear all outputs and counters to 0, including mid-RUN or mid-FLUSH; no o_done SHALL be emitted for an aborted decode.

Configuration
REQ-031 With macro COL_LAYER_EARLY_TERM_EN defined, i_syn_ok=1 in an o_iter_end cycle SHALL send the FSM to FLUSH and set o_early_stop=1, even when the iteration is not the last.
REQ-032 With COL_LAYER_EARLY_TERM_EN undefined, i_syn_ok SHALL be ignored, o_early_stop SHALL be tied to 0, and the decode SHALL always run max_iter iterations.

Verification
REQ-033 The bench SHALL cover: i_start at cycle 0, max_iter=2, no stall -> 192 o_col_vld cycles (cycles 1-192), o_iter_end at cycles 96 and 192, o_is_first_iter high for cycles 1-96 only, o_done at cycle 196.
REQ-034 The bench SHALL cover: i_stall=1 for 5 cycles at col_cnt=40 -> col_cnt holds 40 with o_col_vld=0, and o_done is delayed by exactly 5 cycles.
REQ-035 The bench SHALL cover: with COL_LAYER_EARLY_TERM_EN defined, max_iter=10 and i_syn_ok=1 at the second o_iter_end -> FLUSH, o_early_stop=1, o_done 4 cycles after that o_iter_end; with the macro undefined, the same stimulus -> 10 iterations and o_early_stop=0.
REQ-036 The bench SHALL cover: i_max_iter=0 -> exactly one iteration, then o_done.
REQ-037 The bench SHALL cover: i_start pulsed while busy -> ignored, with no restart and no change to the counters.
REQ-038 The bench SHALL cover: i_rst_n=0 at col_cnt=50, iter 1 -> IDLE next cycle, all outputs 0, no o_done; a new i_start then restarts from column 0, iteration 0.

Source files
------------

// File: rtl/col_layer_ctrl.sv
// Column/iteration sequencer for the layered decoder: walks COL_NUM columns per iteration,
// drains the CN/VN pipeline, then pulses done. Optional macro COL_LAYER_EARLY_TERM_EN adds syndrome early stop.
module col_layer_ctrl #(
  parameter int COL_CNT_WID = 7,
  parameter int COL_NUM     = 96,
  parameter int ITER_WID    = 5,
  parameter int FLUSH_CYC   = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic                   i_stall,
  input  logic [ITER_WID-1:0]    i_max_iter,
  input  logic                   i_syn_ok,
  output logic                   o_busy,
  output logic                   o_col_vld,
  output logic [COL_CNT_WID-1:0] o_col_cnt,
  output logic                   o_is_first_iter,
  output logic [ITER_WID-1:0]    o_iter_cnt,
  output logic                   o_iter_end,
  output logic                   o_done,
  output logic                   o_early_stop
);

  // state | meaning
  // IDLE  | waiting for i_start, counters cleared
  // RUN   | stepping columns, stalls freeze the walk
  // FLUSH | FLUSH_CYC drain cycles, stall ignored
  // DONE  | one-cycle o_done, then back to IDLE
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam int FL_WID = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FL_WID-1:0]      FL_INIT  = FL_WID'(FLUSH_CYC - 1);
  localparam logic [COL_CNT_WID-1:0] COL_LAST = COL_CNT_WID'(COL_NUM - 1);

  state_t                 state_q, state_n;
  logic [COL_CNT_WID-1:0] col_q, col_n;
  logic [ITER_WID-1:0]    iter_q, iter_n, max_q, max_n;
  logic [FL_WID-1:0]      fl_q, fl_n;
  logic first_q, first_n, vld_q, vld_n, end_q, end_n;
  logic done_q, done_n, busy_q, busy_n, early_q, early_n;
  logic last_iter, syn_stop;

`ifdef COL_LAYER_EARLY_TERM_EN
  assign syn_stop = i_syn_ok;
`else
  logic unused_syn_ok;
  assign unused_syn_ok = i_syn_ok;
  assign syn_stop      = 1'b0;
`endif

  assign last_iter = (iter_q == max_q - 1'b1);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      iter_q  <= '0;
      max_q   <= '0;
      fl_q    <= '0;
      first_q <= 1'b0;
      vld_q   <= 1'b0;
      end_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      early_q <= 1'b0;
    end else begin
      state_q <= state_n;
      col_q   <= col_n;
      iter_q  <= iter_n;
      max_q   <= max_n;
      fl_q    <= fl_n;
      first_q <= first_n;
      vld_q   <= vld_n;
      end_q   <= end_n;
      done_q  <= done_n;
      busy_q  <= busy_n;
      early_q <= early_n;
    end
  end

  always_comb begin
    state_n = state_q;
    col_n   = col_q;
    iter_n  = iter_q;
    max_n   = max_q;
    fl_n    = fl_q;
    first_n = first_q;
    busy_n  = busy_q;
    early_n = early_q;
    vld_n   = 1'b0;
    end_n   = 1'b0;
    done_n  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_n = RUN;
          col_n   = '0;
          iter_n  = '0;
          first_n = 1'b1;
          early_n = 1'b0;
          busy_n  = 1'b1;
          vld_n   = 1'b1;
          max_n   = (i_max_iter == '0) ? ITER_WID'(1) : i_max_iter;
        end
      end
      RUN: begin
        // the column on the bus was consumed only if vld_q; end_q already implies vld_q
        if (end_q && (last_iter || syn_stop)) begin
          state_n = FLUSH;
          fl_n    = FL_INIT;
          early_n = syn_stop;
        end else begin
          if (vld_q) begin
            if (end_q) begin
              col_n   = '0;
              iter_n  = iter_q + 1'b1;
              first_n = 1'b0;
            end else begin
              col_n = col_q + 1'b1;
            end
          end
          vld_n = !i_stall;
          end_n = !i_stall && (col_n == COL_LAST);
        end
      end
      FLUSH: begin
        if (fl_q == '0) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          fl_n = fl_q - 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        col_n   = '0;
        iter_n  = '0;
        first_n = 1'b0;
        busy_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  assign o_busy          = busy_q;
  assign o_col_vld       = vld_q;
  assign o_col_cnt       = col_q;
  assign o_is_first_iter = first_q;
  assign o_iter_cnt      = iter_q;
  assign o_iter_end      = end_q;
  assign o_done          = done_q;
  assign o_early_stop    = early_q;

endmodule

// File: tb/tb_col_layer_ctrl.sv
// Self-checking bench for col_layer_ctrl: randomized stall/start/syndrome stimulus scored against a
// column-count model (global column index g -> col = g % COL_NUM, iter = g / COL_NUM).
module tb_col_layer_ctrl;
  localparam int COL_CNT_WID = 7;
  localparam int COL_NUM     = 96;
  localparam int ITER_WID    = 5;
  localparam int FLUSH_CYC   = 3;
`ifdef COL_LAYER_EARLY_TERM_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stall = 1'b0, syn_ok = 1'b0;
  logic [ITER_WID-1:0]    max_iter = '0;
  logic                   o_busy, o_col_vld, o_is_first_iter, o_iter_end, o_done, o_early_stop;
  logic [COL_CNT_WID-1:0] o_col_cnt;
  logic [ITER_WID-1:0]    o_iter_cnt;

  int n_chk = 0, n_pass = 0;
  int obs_ie[$];
  int obs_done, obs_vld_cnt, obs_first_cnt, obs_hold40;
  logic obs_early;

  always #5 clk = ~clk;

  col_layer_ctrl #(.COL_CNT_WID(COL_CNT_WID), .COL_NUM(COL_NUM), .ITER_WID(ITER_WID),
                   .FLUSH_CYC(FLUSH_CYC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stall(stall), .i_max_iter(max_iter),
    .i_syn_ok(syn_ok), .o_busy(o_busy), .o_col_vld(o_col_vld), .o_col_cnt(o_col_cnt),
    .o_is_first_iter(o_is_first_iter), .o_iter_cnt(o_iter_cnt), .o_iter_end(o_iter_end),
    .o_done(o_done), .o_early_stop(o_early_stop));

  // Runs one decode from IDLE, checking every cycle against the model.
  // mode 0: no stall; 1: random stall + start pulses while busy; 2: one 5-cycle stall at column 40
  task automatic run_decode(input int max_in, input int mode, input int syn_iter);
    int g, fl, ph, cyc, iters, stall_left;
    bit vld_e, end_e, early_e, s, y, stall_done, finished;
    logic [4:0] fl_e, fl_o;
    logic [COL_CNT_WID+ITER_WID:0] cn_e, cn_o;
    g = 0; fl = 0; ph = 1; cyc = 0; stall_left = 0;
    iters = (max_in == 0) ? 1 : max_in;
    vld_e = 1'b1; early_e = 1'b0; stall_done = 1'b0; finished = 1'b0;
    obs_ie.delete(); obs_done = -1; obs_vld_cnt = 0; obs_first_cnt = 0; obs_hold40 = 0;
    obs_early = 1'bx;
    @(negedge clk);
    start = 1'b1; max_iter = ITER_WID'(max_in);
    while (!finished && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      end_e = (ph == 1) && vld_e && (g % COL_NUM == COL_NUM - 1);
      fl_e = {ph != 4, (ph == 1) && vld_e, end_e, ph == 3, early_e};
      fl_o = {o_busy, o_col_vld, o_iter_end, o_done, o_early_stop};
      n_chk++;
      if (fl_o !== fl_e)
        $display("FAIL flags cyc %0d busy/vld/end/done/early got %b expected %b", cyc, fl_o, fl_e);
      else n_pass++;
      if (ph == 1 || ph == 4) begin
        cn_e = '0;
        if (ph == 1)
          cn_e = {1'(g / COL_NUM == 0), COL_CNT_WID'(g % COL_NUM), ITER_WID'(g / COL_NUM)};
        cn_o = {o_is_first_iter, o_col_cnt, o_iter_cnt};
        n_chk++;
        if (cn_o !== cn_e)
          $display("FAIL counters cyc %0d first/col/iter got %h expected %h", cyc, cn_o, cn_e);
        else n_pass++;
      end
      if (o_iter_end) obs_ie.push_back(cyc);
      if (o_done && obs_done < 0) begin obs_done = cyc; obs_early = o_early_stop; end
      if (o_col_vld) obs_vld_cnt++;
      if (o_is_first_iter) obs_first_cnt++;
      if (o_busy && !o_col_vld && o_col_cnt == 40) obs_hold40++;
      if (ph == 4) finished = 1'b1;
      else begin
        s = 1'b0;
        if (mode == 1) s = ($urandom_range(0, 99) < 20);
        if (mode == 2 && ph == 1 && vld_e && g == 39 && !stall_done) begin
          stall_left = 5; stall_done = 1'b1;
        end
        if (stall_left > 0) begin s = 1'b1; stall_left--; end
        y = end_e ? (g / COL_NUM == syn_iter) : 1'($urandom_range(0, 1));
        stall = s; syn_ok = y;
        if (mode == 1 && ph < 3) start = ($urandom_range(0, 4) == 0);
        case (ph)
          1: if (end_e && (g / COL_NUM == iters - 1 || (EARLY_EN && y))) begin
               ph = 2; fl = FLUSH_CYC; early_e = EARLY_EN && y;
             end else begin
               if (vld_e) g++;
               vld_e = !s;
             end
          2: begin fl--; if (fl == 0) ph = 3; end
          3: ph = 4;
          default: ;
        endcase
      end
    end
    stall = 1'b0; syn_ok = 1'b0; start = 1'b0;
    n_chk++;
    if (!finished) $display("FAIL timeout decode not back to idle after %0d cycles", cyc);
    else n_pass++;
  endtask

  task automatic test_reset;
    logic [COL_CNT_WID+ITER_WID+5:0] v;
    rst_n = 1'b0; start = 1'b1; max_iter = 5'd2;
    repeat (3) @(negedge clk);
    v = {o_busy, o_col_vld, o_iter_end, o_done, o_early_stop, o_is_first_iter, o_col_cnt, o_iter_cnt};
    n_chk++;
    if (v !== '0) $display("FAIL reset_outputs got %h expected 0", v); else n_pass++;
    start = 1'b0; rst_n = 1'b1;
    repeat (2) @(negedge clk);
    v = {o_busy, o_col_vld, o_iter_end, o_done, o_early_stop, o_is_first_iter, o_col_cnt, o_iter_cnt};
    n_chk++;
    if (v !== '0) $display("FAIL idle_outputs got %h expected 0", v); else n_pass++;
  endtask

  task automatic test_basic;
    run_decode(2, 0, -1);
    n_chk++;
    if (obs_ie.size() != 2 || obs_ie[0] != 96 || obs_ie[1] != 192)
      $display("FAIL basic_iter_end got %0d ends (first %0d) expected cycles 96,192",
               obs_ie.size(), (obs_ie.size() > 0) ? obs_ie[0] : -1);
    else n_pass++;
    n_chk++;
    if (obs_done != 196) $display("FAIL basic_done got cycle %0d expected 196", obs_done);
    else n_pass++;
    n_chk++;
    if (obs_vld_cnt != 192) $display("FAIL basic_vld_count got %0d expected 192", obs_vld_cnt);
    else n_pass++;
    n_chk++;
    if (obs_first_cnt != 96) $display("FAIL basic_first_iter got %0d expected 96", obs_first_cnt);
    else n_pass++;
  endtask

  task automatic test_stall;
    run_decode(2, 2, -1);
    n_chk++;
    if (obs_hold40 != 5) $display("FAIL stall_hold got %0d expected 5", obs_hold40);
    else n_pass++;
    n_chk++;
    if (obs_done != 201) $display("FAIL stall_done got cycle %0d expected 201", obs_done);
    else n_pass++;
  endtask

  task automatic test_early_term;
    int n_end, last_end;
    run_decode(10, 0, 1);
    n_end    = EARLY_EN ? 2 : 10;
    last_end = n_end * COL_NUM;
    n_chk++;
    if (obs_ie.size() != n_end) $display("FAIL early_iter_count got %0d expected %0d", obs_ie.size(), n_end);
    else n_pass++;
    n_chk++;
    if (obs_done != last_end + 4) $display("FAIL early_done got cycle %0d expected %0d", obs_done, last_end + 4);
    else n_pass++;
    n_chk++;
    if (obs_early !== EARLY_EN) $display("FAIL early_flag got %b expected %b", obs_early, EARLY_EN);
    else n_pass++;
  endtask

  task automatic test_zero_iter;
    run_decode(0, 0, -1);
    n_chk++;
    if (obs_ie.size() != 1) $display("FAIL zero_iter_count got %0d expected 1", obs_ie.size());
    else n_pass++;
    n_chk++;
    if (obs_done != 100) $display("FAIL zero_iter_done got cycle %0d expected 100", obs_done);
    else n_pass++;
  endtask

  task automatic test_busy_start;
    run_decode(2, 1, -1);
    n_chk++;
    if (obs_ie.size() != 2) $display("FAIL busy_start_iters got %0d expected 2", obs_ie.size());
    else n_pass++;
  endtask

  task automatic test_random;
    for (int r = 0; r < 4; r++)
      run_decode(int'($urandom_range(0, 3)), 1, int'($urandom_range(0, 3)));
  endtask

  task automatic test_reset_abort;
    bit found, seen_done;
    logic [COL_CNT_WID+ITER_WID+5:0] v;
    logic [COL_CNT_WID+ITER_WID+2:0] r;
    @(negedge clk);
    start = 1'b1; max_iter = 5'd3;
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (o_col_cnt == 50 && o_iter_cnt == 1 && o_col_vld) found = 1'b1;
    end
    n_chk++;
    if (!found) $display("FAIL abort_reach got no col 50 iter 1 expected it within 400 cycles");
    else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    v = {o_busy, o_col_vld, o_iter_end, o_done, o_early_stop, o_is_first_iter, o_col_cnt, o_iter_cnt};
    n_chk++;
    if (v !== '0) $display("FAIL abort_outputs got %h expected 0", v); else n_pass++;
    seen_done = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (o_done || o_busy) seen_done = 1'b1;
    end
    n_chk++;
    if (seen_done) $display("FAIL abort_no_done got activity after reset expected none");
    else n_pass++;
    start = 1'b1; max_iter = 5'd1;
    @(negedge clk);
    start = 1'b0;
    r = {o_busy, o_col_vld, o_is_first_iter, o_col_cnt, o_iter_cnt};
    n_chk++;
    if (r !== {3'b111, {(COL_CNT_WID+ITER_WID){1'b0}}})
      $display("FAIL abort_restart got %h expected busy/vld/first set, col 0, iter 0", r);
    else n_pass++;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (o_done) found = 1'b1;
    end
    n_chk++;
    if (!found) $display("FAIL abort_rerun_done got no o_done expected one within 200 cycles");
    else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_early_term();
    test_zero_iter();
    test_busy_start();
    test_random();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
